fpu_unpack_sequencer: RTL and testbench

- Shares one combinational FP unpack/classify unit between the three FPU source operands X, Y and Z, instead of instantiating three copies.
- Accepts a request bundle through a valid/ready handshake. Drives the shared unit one enabled operand per cycle, then captures sign, exponent, mantissa and class flags into per-slot registers.
- Presents the full result bundle to the FPU issue logic through a second valid/ready handshake.
- Sits between FPU operand read and the FMA/divsqrt/convert front ends.

---
 rtl/fpu_unpack_sequencer.sv | 175 +++++++++++++++++
 tb/tb_fpu_unpack_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_unpack_sequencer.sv
// Time-multiplexes one shared FP unpack/classify unit over the X, Y and Z source operands.
// Optional macro FPU_UNPACK_SEQ_PIPELINE_EN: accept the next request on the response handshake edge.
module fpu_unpack_sequencer #(
  parameter int FLEN    = 64,
  parameter int NE      = 11,
  parameter int NF      = 52,
  parameter int FMTBITS = 2,
  parameter int TAGW    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Flush,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [FLEN-1:0]       ReqX,
  input  logic [FLEN-1:0]       ReqY,
  input  logic [FLEN-1:0]       ReqZ,
  input  logic [FMTBITS-1:0]    ReqFmt,
  input  logic [2:0]            ReqMask,
  input  logic [TAGW-1:0]       ReqTag,
  output logic [FLEN-1:0]       UnpkA,
  output logic                  UnpkEn,
  output logic [FMTBITS-1:0]    UnpkFmt,
  output logic                  UnpkActive,
  input  logic                  UnpkSgn,
  input  logic [NE-1:0]         UnpkExp,
  input  logic [NF:0]           UnpkMan,
  input  logic [5:0]            UnpkFlags,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [2:0]            RspSgn,
  output logic [3*NE-1:0]       RspExp,
  output logic [3*(NF+1)-1:0]   RspMan,
  output logic [17:0]           RspFlags,
  output logic [2:0]            RspMask,
  output logic [TAGW-1:0]       RspTag
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] UNPK = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]         state_r;
  logic [1:0]         slot_r;
  logic [FLEN-1:0]    opx_r;
  logic [FLEN-1:0]    opy_r;
  logic [FLEN-1:0]    opz_r;
  logic [FMTBITS-1:0] fmt_r;
  logic               accept_s;
  logic [2:0]         first_s;
  logic [2:0]         next_s;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [2:0] seek_slot(input logic [2:0] mask, input logic [1:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (2'(i) >= from)) begin
        res = {1'b1, 2'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Request handshake and slot search.
  always_comb begin
`ifdef FPU_UNPACK_SEQ_PIPELINE_EN
    ReqReady = (state_r == IDLE) | ((state_r == DONE) & RspReady);
`else
    ReqReady = (state_r == IDLE);
`endif
    accept_s = ReqValid & ReqReady & ~Flush;
    first_s  = seek_slot(ReqMask, 2'd0);
    next_s   = seek_slot(RspMask, slot_r + 2'd1);
  end

  // Shared unpack unit is only driven while a slot is being unpacked.
  always_comb begin
    UnpkA      = {FLEN{1'b0}};
    UnpkEn     = 1'b0;
    UnpkActive = 1'b0;
    UnpkFmt    = fmt_r;
    if (state_r == UNPK) begin
      UnpkEn     = 1'b1;
      UnpkActive = 1'b1;
      case (slot_r)
        2'd0:    UnpkA = opx_r;
        2'd1:    UnpkA = opy_r;
        2'd2:    UnpkA = opz_r;
        default: UnpkA = {FLEN{1'b0}};
      endcase
    end else begin
      UnpkA = {FLEN{1'b0}};
    end
  end

  // Sequencer state, captured request and per-slot result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      slot_r   <= 2'd0;
      opx_r    <= {FLEN{1'b0}};
      opy_r    <= {FLEN{1'b0}};
      opz_r    <= {FLEN{1'b0}};
      fmt_r    <= {FMTBITS{1'b0}};
      RspValid <= 1'b0;
      RspSgn   <= 3'b000;
      RspExp   <= {(3*NE){1'b0}};
      RspMan   <= {(3*(NF+1)){1'b0}};
      RspFlags <= 18'd0;
      RspMask  <= 3'b000;
      RspTag   <= {TAGW{1'b0}};
    end else if (Flush) begin
      state_r  <= IDLE;
      RspValid <= 1'b0;
    end else if (accept_s) begin
      opx_r    <= ReqX;
      opy_r    <= ReqY;
      opz_r    <= ReqZ;
      fmt_r    <= ReqFmt;
      RspMask  <= ReqMask;
      RspTag   <= ReqTag;
      RspSgn   <= 3'b000;
      RspExp   <= {(3*NE){1'b0}};
      RspMan   <= {(3*(NF+1)){1'b0}};
      RspFlags <= 18'd0;
      slot_r   <= first_s[1:0];
      // An empty mask has nothing to unpack and responds with all-zero results.
      if (first_s[2]) begin
        state_r  <= UNPK;
        RspValid <= 1'b0;
      end else begin
        state_r  <= DONE;
        RspValid <= 1'b1;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        UNPK: begin
          for (int i = 0; i < 3; i++) begin
            if (slot_r == 2'(i)) begin
              RspSgn[i]                  <= UnpkSgn;
              RspExp[i*NE +: NE]         <= UnpkExp;
              RspMan[i*(NF+1) +: (NF+1)] <= UnpkMan;
              RspFlags[i*6 +: 6]         <= UnpkFlags;
            end
          end
          if (next_s[2]) begin
            slot_r <= next_s[1:0];
          end else begin
            state_r  <= DONE;
            RspValid <= 1'b1;
          end
        end
        DONE: begin
          if (RspReady) begin
            state_r  <= IDLE;
            RspValid <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r  <= IDLE;
          RspValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_unpack_sequencer.sv
// Directed bench for fpu_unpack_sequencer with a behavioural double/single unpack unit attached.
module tb_fpu_unpack_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, Flush, ReqValid, ReqReady, RspValid, RspReady;
  logic [63:0]  ReqX, ReqY, ReqZ, UnpkA;
  logic [1:0]   ReqFmt, UnpkFmt;
  logic [2:0]   ReqMask, RspMask, RspSgn;
  logic [3:0]   ReqTag, RspTag;
  logic         UnpkEn, UnpkActive, UnpkSgn;
  logic [10:0]  UnpkExp;
  logic [52:0]  UnpkMan;
  logic [5:0]   UnpkFlags;
  logic [32:0]  RspExp;
  logic [158:0] RspMan;
  logic [17:0]  RspFlags;

  int checks = 0;
  int failures = 0;

  fpu_unpack_sequencer dut (
    .clk(clk), .reset(reset), .Flush(Flush),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqX(ReqX), .ReqY(ReqY), .ReqZ(ReqZ),
    .ReqFmt(ReqFmt), .ReqMask(ReqMask), .ReqTag(ReqTag),
    .UnpkA(UnpkA), .UnpkEn(UnpkEn), .UnpkFmt(UnpkFmt), .UnpkActive(UnpkActive),
    .UnpkSgn(UnpkSgn), .UnpkExp(UnpkExp), .UnpkMan(UnpkMan), .UnpkFlags(UnpkFlags),
    .RspValid(RspValid), .RspReady(RspReady),
    .RspSgn(RspSgn), .RspExp(RspExp), .RspMan(RspMan), .RspFlags(RspFlags),
    .RspMask(RspMask), .RspTag(RspTag)
  );

  // Behavioural unpack unit: Fmt 01 = double, otherwise NaN-boxed single widened to double range.
  logic [31:0] m_a32;
  logic        m_emax, m_ezero, m_fz, m_fmsb, m_nan;
  always_comb begin
    m_a32 = 32'd0; m_emax = 1'b0; m_ezero = 1'b0; m_fz = 1'b0; m_fmsb = 1'b0;
    UnpkSgn = 1'b0; UnpkExp = 11'd0; UnpkMan = 53'd0;
    if (UnpkFmt == 2'b01) begin
      UnpkSgn = UnpkA[63];
      m_emax  = &UnpkA[62:52];
      m_ezero = (UnpkA[62:52] == 11'd0);
      m_fz    = (UnpkA[51:0] == 52'd0);
      m_fmsb  = UnpkA[51];
      UnpkExp = UnpkA[62:52];
      UnpkMan = {~m_ezero, UnpkA[51:0]};
    end else begin
      m_a32   = (UnpkA[63:32] == 32'hFFFFFFFF) ? UnpkA[31:0] : 32'h7FC00000;
      UnpkSgn = m_a32[31];
      m_emax  = &m_a32[30:23];
      m_ezero = (m_a32[30:23] == 8'd0);
      m_fz    = (m_a32[22:0] == 23'd0);
      m_fmsb  = m_a32[22];
      UnpkExp = m_emax ? 11'h7FF : (m_ezero ? 11'h000 : ({3'b000, m_a32[30:23]} + 11'd896));
      UnpkMan = {~m_ezero, m_a32[22:0], 29'd0};
    end
    m_nan     = m_emax & ~m_fz;
    UnpkFlags = {m_nan, m_nan & ~m_fmsb, m_ezero & m_fz, m_emax & m_fz, m_emax, m_ezero & ~m_fz};
  end

  // Monitors: count enabled unpack cycles, log driven operands, count RspValid-high cycles.
  int          en_cnt = 0;
  int          rv_cnt = 0;
  int          seq_n = 0;
  logic [63:0] seq [0:63];
  always @(posedge clk) begin
    if (UnpkEn && UnpkActive) begin
      en_cnt <= en_cnt + 1;
      if (seq_n < 64) begin
        seq[seq_n] <= UnpkA;
        seq_n      <= seq_n + 1;
      end
    end
    if (RspValid) rv_cnt <= rv_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic handshake();
    RspReady = 1'b1;
    step();
    RspReady = 1'b0;
  endtask

  // Presents one request; lat counts cycles from the accept cycle until RspValid is seen.
  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z,
                      input logic [1:0] fmt, input logic [2:0] mask, input logic [3:0] tag,
                      output int lat);
    int guard;
    ReqX = x; ReqY = y; ReqZ = z; ReqFmt = fmt; ReqMask = mask; ReqTag = tag;
    ReqValid = 1'b1;
    guard = 0;
    while (!ReqReady && guard < 20) begin
      step();
      guard++;
    end
    step();
    ReqValid = 1'b0;
    ReqX = 64'd0; ReqY = 64'd0; ReqZ = 64'd0; ReqMask = 3'b000; ReqTag = 4'h0;
    lat = 1;
    while (!RspValid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  int lat, en0, sq0, rv0, acc, r1, r2;
  logic prev;

  initial begin
    reset = 1'b1; Flush = 1'b0; ReqValid = 1'b0; RspReady = 1'b0;
    ReqX = 64'd0; ReqY = 64'd0; ReqZ = 64'd0; ReqFmt = 2'b00; ReqMask = 3'b000; ReqTag = 4'h0;
    step(); step();
    reset = 1'b0;
    chk("rst_reqready", ReqReady, 1'b1);
    chk("rst_rspvalid", RspValid, 1'b0);
    chk("rst_unpken", UnpkEn, 1'b0);
    chk("rst_results", {RspSgn, RspExp, RspMan, RspFlags, RspMask, RspTag}, 256'd0);

    // Double, X only
    en0 = en_cnt;
    send(64'h3FF0000000000000, 64'h0, 64'h0, 2'b01, 3'b001, 4'h5, lat);
    chk("x_only_lat", lat, 2);
    chk("x_only_en_cycles", en_cnt - en0, 1);
    chk("x_only_exp0", RspExp[10:0], 11'h3FF);
    chk("x_only_man0", RspMan[52:0], 53'h10000000000000);
    chk("x_only_flags0", RspFlags[5:0], 6'b000000);
    chk("x_only_sgn", RspSgn, 3'b000);
    chk("x_only_slots12", {RspExp[32:11], RspMan[158:53], RspFlags[17:6]}, 256'd0);
    chk("x_only_tag", RspTag, 4'h5);
    chk("x_only_mask", RspMask, 3'b001);
    handshake();
    chk("x_only_after_valid", RspValid, 1'b0);
    chk("x_only_after_ready", ReqReady, 1'b1);
    chk("x_only_retained", RspExp[10:0], 11'h3FF);

    // Double, all three slots, then backpressure
    en0 = en_cnt; sq0 = seq_n;
    send(64'h7FF8000000000000, 64'h0000000000000001, 64'h0, 2'b01, 3'b111, 4'h3, lat);
    chk("m111_lat", lat, 4);
    chk("m111_en_cycles", en_cnt - en0, 3);
    chk("m111_seq_x", seq[sq0], 64'h7FF8000000000000);
    chk("m111_seq_y", seq[sq0+1], 64'h0000000000000001);
    chk("m111_seq_z", seq[sq0+2], 64'h0);
    chk("m111_flags", RspFlags, {6'b001000, 6'b000001, 6'b100010});
    chk("m111_man_y", RspMan[105:53], 53'h1);
    chk("m111_exp_x", RspExp[10:0], 11'h7FF);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rspvalid", RspValid, 1'b1);
      chk("bp_reqready", ReqReady, 1'b0);
      chk("bp_flags_stable", RspFlags, {6'b001000, 6'b000001, 6'b100010});
      step();
    end
    handshake();

    // Single, mask 101: Y skipped, Z badly NaN-boxed
    en0 = en_cnt; sq0 = seq_n;
    send(64'hFFFFFFFF3F800000, 64'h1234, 64'h00000000BF800000, 2'b00, 3'b101, 4'h9, lat);
    chk("m101_lat", lat, 3);
    chk("m101_en_cycles", en_cnt - en0, 2);
    chk("m101_seq_x", seq[sq0], 64'hFFFFFFFF3F800000);
    chk("m101_seq_z", seq[sq0+1], 64'h00000000BF800000);
    chk("m101_exp_x", RspExp[10:0], 11'h3FF);
    chk("m101_man_x", RspMan[52:0], 53'h10000000000000);
    chk("m101_sgn", RspSgn, 3'b000);
    chk("m101_flags_z", RspFlags[17:12], 6'b100010);
    chk("m101_slot1_zero", {RspExp[21:11], RspMan[105:53], RspFlags[11:6]}, 256'd0);
    handshake();

    // Empty mask
    en0 = en_cnt;
    send(64'h3FF0000000000000, 64'h7FF8000000000000, 64'h1, 2'b01, 3'b000, 4'hA, lat);
    chk("m000_lat", lat, 1);
    chk("m000_en_cycles", en_cnt - en0, 0);
    chk("m000_results", {RspSgn, RspExp, RspMan, RspFlags, RspMask}, 256'd0);
    chk("m000_tag", RspTag, 4'hA);
    handshake();

    // Flush alongside ReqValid in IDLE is not an accept
    ReqMask = 3'b001; ReqX = 64'h3FF0000000000000; ReqFmt = 2'b01;
    Flush = 1'b1; ReqValid = 1'b1;
    step();
    Flush = 1'b0; ReqValid = 1'b0;
    chk("flush_idle_unpken", UnpkEn, 1'b0);
    chk("flush_idle_reqready", ReqReady, 1'b1);

    // Flush in the second UNPK cycle of a mask 111 request
    rv0 = rv_cnt;
    ReqMask = 3'b111; ReqValid = 1'b1;
    step();
    ReqValid = 1'b0;
    chk("flush_unpk_first", UnpkEn, 1'b1);
    step();
    chk("flush_unpk_second_a", UnpkA, 64'h0);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("flush_reqready", ReqReady, 1'b1);
    chk("flush_unpken", UnpkEn, 1'b0);
    repeat (6) step();
    chk("flush_no_rspvalid", rv_cnt - rv0, 0);
    send(64'h0, 64'h4000000000000000, 64'h0, 2'b01, 3'b010, 4'h7, lat);
    chk("post_flush_lat", lat, 2);
    chk("post_flush_exp1", RspExp[21:11], 11'h400);
    chk("post_flush_man1", RspMan[105:53], 53'h10000000000000);
    chk("post_flush_mask", RspMask, 3'b010);
    chk("post_flush_slot0", {RspExp[10:0], RspFlags[5:0]}, 256'd0);
    handshake();

    // Back-to-back requests with RspReady held high
    ReqX = 64'h3FF0000000000000; ReqFmt = 2'b01; ReqMask = 3'b001; ReqTag = 4'h2;
    ReqValid = 1'b1; RspReady = 1'b1;
    acc = 0; r1 = -1; r2 = -1; prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (ReqValid && ReqReady) acc++;
      step();
      if (acc >= 2) ReqValid = 1'b0;
      if (RspValid && !prev) begin
        if (r1 < 0) r1 = c;
        else if (r2 < 0) r2 = c;
      end
      prev = RspValid;
    end
    RspReady = 1'b0;
    chk("b2b_two_pulses", (r1 >= 0) && (r2 >= 0), 1'b1);
`ifdef FPU_UNPACK_SEQ_PIPELINE_EN
    chk("b2b_gap", r2 - r1 - 1, 1);
`else
    chk("b2b_gap", r2 - r1 - 1, 2);
`endif
    chk("b2b_exp0", RspExp[10:0], 11'h3FF);
    chk("b2b_idle", {ReqReady, RspValid}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
